// File: rtl/fpu16_wrap.sv
// rtl/fpu16_wrap.sv - FP16 fused multiply-add unit behind a valid/ready handshake with one output register
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   operands_i   {c, b, a}, each a binary16 value (a = [15:0])
//   op_i         0 FMADD, 1 FNMSUB, 2 ADD, 3 MUL; other codes are invalid
//   op_mod_i     negates the addend
//   rnd_mode_i   0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE
//   in_valid_i   request valid
//   in_ready_o   request accepted when in_valid_i && in_ready_o
//   flush_i      kills any pending result; blocks acceptance while high
//   result_o     binary16 result
//   status_o     {NV, DZ, OF, UF, NX}
//   out_valid_o  result/status valid
//   out_ready_i  consumer takes the result
//   busy_o       same as out_valid_o
module fpu16_wrap #(
  parameter int WIDTH        = 16,
  parameter int NUM_OPERANDS = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_OPERANDS*WIDTH-1:0] operands_i,
  input  logic [3:0]                    op_i,
  input  logic                          op_mod_i,
  input  logic [2:0]                    rnd_mode_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          flush_i,
  output logic [WIDTH-1:0]              result_o,
  output logic [4:0]                    status_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o
);

  localparam logic [3:0] OP_FNMSUB = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_MUL    = 4'd3;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // Every finite operand, product and sum is an exact integer multiple of
  // 2^-48 (product of two minimum subnormals) and below 2^33, so the whole
  // computation is done exactly on this fixed-point grid and rounded once.
  localparam int MW = 82;

  function automatic logic [10:0] sig_of(input logic [15:0] x);
    return {|x[14:10], x[9:0]};
  endfunction

  // Subnormals share the scale of exponent 1.
  function automatic logic [4:0] exp_of(input logic [15:0] x);
    return (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
  endfunction

  function automatic logic is_zero(input logic [15:0] x);
    return x[14:0] == 15'd0;
  endfunction

  logic [15:0]   fa, fb, fc;
  logic [2:0]    rm;
  logic          op_ok, no_addend;
  logic          ps, cs, rs, zsign;
  logic          any_nan, any_snan, inv_mul, inv_add, prod_inf, inf_c;
  logic [21:0]   sig_p;
  logic [5:0]    psh, csh;
  logic [MW-1:0] mp, mc, mag;
  logic [6:0]    lead, lsb_pos, exp_field;
  logic          normal, rb, st, lsb, inc, ovf, ovf_inf, nx, uf;
  logic [9:0]    mant;
  logic [16:0]   packed_res;
  logic [15:0]   res;
  logic [4:0]    stat;
  logic          accept;

  always_comb begin
    rm        = (rnd_mode_i > 3'd4) ? RM_RNE : rnd_mode_i;
    op_ok     = (op_i <= 4'd3);
    no_addend = (op_i == OP_MUL);

    // ADD becomes 1.0*b + c; MUL becomes a*b + (-0) with the zero sign fixed below.
    fa = (op_i == OP_ADD) ? 16'h3C00 : operands_i[15:0];
    fb = operands_i[31:16];
    fc = (op_i == OP_MUL) ? 16'h8000 : operands_i[47:32];

    ps = fa[15] ^ fb[15] ^ (op_i == OP_FNMSUB);
    cs = fc[15] ^ op_mod_i;

    any_nan  = is_nan(fa) | is_nan(fb) | is_nan(fc);
    any_snan = (is_nan(fa) & ~fa[9]) | (is_nan(fb) & ~fb[9]) | (is_nan(fc) & ~fc[9]);
    inv_mul  = (is_inf(fa) & is_zero(fb)) | (is_zero(fa) & is_inf(fb));
    prod_inf = is_inf(fa) | is_inf(fb);
    inf_c    = is_inf(fc);
    inv_add  = prod_inf & inf_c & (ps != cs);

    // Exact magnitudes on the 2^-48 grid.
    sig_p = sig_of(fa) * sig_of(fb);
    psh   = {1'b0, exp_of(fa)} + {1'b0, exp_of(fb)} - 6'd2;
    csh   = {1'b0, exp_of(fc)} + 6'd23;
    mp    = MW'(sig_p) << psh;
    mc    = MW'(sig_of(fc)) << csh;

    if (ps == cs)      mag = mp + mc;
    else if (mp >= mc) mag = mp - mc;
    else               mag = mc - mp;

    // Exact zero: a bare product keeps its sign, like-signed zeros keep
    // theirs, otherwise +0 except -0 when rounding down.
    if (no_addend)     zsign = ps;
    else if (ps == cs) zsign = ps;
    else               zsign = (rm == RM_RDN);

    if (mag == '0)     rs = zsign;
    else if (ps == cs) rs = ps;
    else               rs = (mp >= mc) ? ps : cs;

    lead = 7'd0;
    for (int i = 0; i < MW; i++) begin
      if (mag[i]) lead = 7'(i);
    end

    // Bit 33 is 2^-15; leading one at 34 or above is a normal result.
    // Subnormals always keep bit 24 (2^-24) as their LSB.
    normal    = (lead >= 7'd34);
    lsb_pos   = normal ? (lead - 7'd10) : 7'd24;
    exp_field = normal ? (lead - 7'd33) : 7'd0;
    mant      = 10'(mag >> lsb_pos);
    lsb       = mant[0];
    rb        = mag[lsb_pos - 7'd1];
    st        = |(mag << (7'd83 - lsb_pos));

    case (rm)
      RM_RNE:  inc = rb & (st | lsb);
      RM_RDN:  inc = rs & (rb | st);
      RM_RUP:  inc = ~rs & (rb | st);
      RM_RMM:  inc = rb;
      default: inc = 1'b0;
    endcase

    // A mantissa carry ripples into the exponent field, which also turns
    // a subnormal rounding up into the minimum normal.
    packed_res = {exp_field, mant} + 17'(inc);
    ovf        = (packed_res[16:10] >= 7'd31);
    ovf_inf    = (rm == RM_RNE) | (rm == RM_RMM) | ((rm == RM_RDN) & rs) | ((rm == RM_RUP) & ~rs);
    nx         = rb | st;
    uf         = nx & (packed_res[16:10] == 7'd0);

    res  = 16'h0000;
    stat = 5'b00000;
    if (!op_ok) begin
      res  = 16'h7E00;
      stat = 5'b10000;
    end else if (any_nan | inv_mul | inv_add) begin
      res  = 16'h7E00;
      stat = {any_snan | ((inv_mul | inv_add) & ~any_nan), 4'b0000};
    end else if (prod_inf) begin
      res = {ps, 15'h7C00};
    end else if (inf_c) begin
      res = {cs, 15'h7C00};
    end else if (ovf) begin
      res  = ovf_inf ? {rs, 15'h7C00} : {rs, 15'h7BFF};
      stat = 5'b00101;
    end else begin
      res  = {rs, packed_res[14:0]};
      stat = {3'b000, uf, nx};
    end
  end

  assign in_ready_o = (!out_valid_o || out_ready_i) && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = out_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      status_o    <= 5'b00000;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      result_o    <= WIDTH'(res);
      status_o    <= stat;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu16_wrap.sv
// tb/tb_fpu16_wrap.sv - directed self-checking bench for fpu16_wrap
module tb_fpu16_wrap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] operands;
  logic [3:0]  op;
  logic        op_mod;
  logic [2:0]  rnd_mode;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] result;
  logic [4:0]  status;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu16_wrap #(.WIDTH(16), .NUM_OPERANDS(3)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .operands_i  (operands),
    .op_i        (op),
    .op_mod_i    (op_mod),
    .rnd_mode_i  (rnd_mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .flush_i     (flush),
    .result_o    (result),
    .status_o    (status),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic m, input logic [2:0] r,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    op       = o;
    op_mod   = m;
    rnd_mode = r;
    operands = {c, b, a};
    in_valid = 1'b1;
  endtask

  // Issue one op with the consumer ready and check it one cycle after accept.
  task automatic run(input string tag, input logic [3:0] o, input logic m, input logic [2:0] r,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                     input logic [15:0] er, input logic [4:0] es);
    drive(o, m, r, a, b, c);
    out_ready = 1'b1;
    #1;
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "/out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "/result"}, 32'(result), 32'(er));
    check({tag, "/status"}, 32'(status), 32'(es));
  endtask

  initial begin
    rst_n     = 1'b0;
    operands  = '0;
    op        = 4'd0;
    op_mod    = 1'b0;
    rnd_mode  = 3'd0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/result", 32'(result), 32'h0000);
    check("rst/status", 32'(status), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst/in_ready", 32'(in_ready), 32'd1);

    //  tag            op    mod   rm    a         b         c         result    status
    run("add_1p2",     4'd2, 1'b0, 3'd0, 16'h0000, 16'h3C00, 16'h4000, 16'h4200, 5'b00000);
    run("fmadd",       4'd0, 1'b0, 3'd0, 16'h4000, 16'h4200, 16'h3C00, 16'h4700, 5'b00000);
    run("fmsub",       4'd0, 1'b1, 3'd0, 16'h4000, 16'h4200, 16'h3C00, 16'h4500, 5'b00000);
    run("fnmsub",      4'd1, 1'b0, 3'd0, 16'h4000, 16'h4200, 16'h3C00, 16'hC500, 5'b00000);
    run("fnmadd",      4'd1, 1'b1, 3'd0, 16'h4000, 16'h4200, 16'h3C00, 16'hC700, 5'b00000);
    run("mul_of_rne",  4'd3, 1'b0, 3'd0, 16'h7BFF, 16'h4000, 16'h0000, 16'h7C00, 5'b00101);
    run("mul_of_rtz",  4'd3, 1'b0, 3'd1, 16'h7BFF, 16'h4000, 16'h0000, 16'h7BFF, 5'b00101);
    run("mul_of_rup_n",4'd3, 1'b0, 3'd3, 16'hFBFF, 16'h4000, 16'h0000, 16'hFBFF, 5'b00101);
    run("add_inf_inf", 4'd2, 1'b0, 3'd0, 16'h0000, 16'h7C00, 16'hFC00, 16'h7E00, 5'b10000);
    run("mul_inf_0",   4'd3, 1'b0, 3'd0, 16'h7C00, 16'h0000, 16'h0000, 16'h7E00, 5'b10000);
    run("mul_snan",    4'd3, 1'b0, 3'd0, 16'h7D00, 16'h3C00, 16'h0000, 16'h7E00, 5'b10000);
    run("add_qnan",    4'd2, 1'b0, 3'd0, 16'h0000, 16'h7E00, 16'h3C00, 16'h7E00, 5'b00000);
    run("bad_op",      4'd5, 1'b0, 3'd0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h7E00, 5'b10000);
    run("mul_uf",      4'd3, 1'b0, 3'd0, 16'h0001, 16'h3800, 16'h0000, 16'h0000, 5'b00011);
    run("mul_sub2nrm", 4'd3, 1'b0, 3'd0, 16'h0200, 16'h4000, 16'h0000, 16'h0400, 5'b00000);
    run("tie_rne",     4'd2, 1'b0, 3'd0, 16'h0000, 16'h3C00, 16'h1000, 16'h3C00, 5'b00001);
    run("tie_rup",     4'd2, 1'b0, 3'd3, 16'h0000, 16'h3C00, 16'h1000, 16'h3C01, 5'b00001);
    run("tie_rm7",     4'd2, 1'b0, 3'd7, 16'h0000, 16'h3C00, 16'h1000, 16'h3C00, 5'b00001);
    run("zero_rne",    4'd2, 1'b1, 3'd0, 16'h0000, 16'h3C00, 16'h3C00, 16'h0000, 5'b00000);
    run("zero_rdn",    4'd2, 1'b1, 3'd2, 16'h0000, 16'h3C00, 16'h3C00, 16'h8000, 5'b00000);

    // Ready consumer, no new request: result drains on this edge.
    @(posedge clk);
    #1;
    check("drain/out_valid", 32'(out_valid), 32'd0);

    // Backpressure: hold out_ready low for three cycles with the next op waiting.
    out_ready = 1'b0;
    drive(4'd2, 1'b0, 3'd0, 16'h0000, 16'h3C00, 16'h4000);
    @(posedge clk);
    #1;
    drive(4'd0, 1'b0, 3'd0, 16'h4000, 16'h4200, 16'h3C00);
    for (int i = 0; i < 3; i++) begin
      check("hold/out_valid", 32'(out_valid), 32'd1);
      check("hold/result", 32'(result), 32'h4200);
      check("hold/status", 32'(status), 32'd0);
      check("hold/in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("release/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("release/out_valid", 32'(out_valid), 32'd1);
    check("release/result", 32'(result), 32'h4700);

    // Flush a pending result while a request is also offered.
    out_ready = 1'b0;
    drive(4'd2, 1'b0, 3'd0, 16'h0000, 16'h3C00, 16'h3C00);
    flush = 1'b1;
    #1;
    check("flush/in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush/out_valid", 32'(out_valid), 32'd0);
    check("flush/busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("flush/no_accept", 32'(out_valid), 32'd0);

    // Asynchronous reset drops a pending result at once.
    run("pre_rst", 4'd2, 1'b0, 3'd0, 16'h0000, 16'h3C00, 16'h4000, 16'h4200, 5'b00000);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst/out_valid", 32'(out_valid), 32'd0);
    check("midrst/result", 32'(result), 32'h0000);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
